// File: rtl/mcs4_pkg.sv
// Shared MCS-4 types: nibble/byte aliases, ROM address, loader state encoding
// and checksum width.
package mcs4;

    typedef logic [3:0] char_t;
    typedef logic [7:0] byte_t;
    typedef char_t [2:0] rom_addr_t;

    localparam int unsigned CSUM_W = 8;
    typedef logic [CSUM_W-1:0] csum_t;

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        LOAD,
        RELEASE
    } loader_state_t;

endpackage

// File: rtl/mcs4_loader_if.sv
// Host image stream: valid/ready byte handshake with an end-of-image marker.
interface mcs4_loader_if;
    import mcs4::*;

    byte_t host_data;
    logic  host_valid;
    logic  host_last;
    logic  host_ready;

    modport master (output host_data, host_valid, host_last, input host_ready);
    modport slave  (input host_data, host_valid, host_last, output host_ready);

endinterface

// File: rtl/mcs4_loader.sv
// mcs4_loader: holds the MCS-4 system in reset and streams a host byte image into i4001 ROM.
// Define MCS4_LOADER_CHECKSUM_EN to treat the host_last byte as a mod-256 checksum.
module mcs4_loader
    import mcs4::*;
#(
    parameter int unsigned MAX_BYTES     = 256,
    parameter int unsigned HALT_CYCLES   = 4,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [11:0]  base_addr,
    mcs4_loader_if.slave host,
    output rom_addr_t    dbg_addr,
    output byte_t        dbg_wdata,
    output logic         dbg_wen,
    output logic         sys_rst,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned HC_W  = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

    loader_state_t    state, state_nx;
    logic [11:0]      base_q, base_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [HC_W-1:0]  halt_cnt, halt_cnt_nx;
    logic             last_seen, last_nx;
    logic [11:0]      addr_nx;
    byte_t            wdata_nx;
    logic             wen_nx, sys_rst_nx, err_nx;
    logic             hs, is_payload, csum_bad;

    assign hs = host.host_valid && host.host_ready;

`ifdef MCS4_LOADER_CHECKSUM_EN
    csum_t csum;

    assign is_payload = !host.host_last;
    assign csum_bad   = (csum != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            csum <= '0;
        else if (state == IDLE && start)
            csum <= '0;
        else if (state == LOAD && hs)
            csum <= csum + host.host_data;
    end
`else
    assign is_payload = 1'b1;
    assign csum_bad   = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        base_nx     = base_q;
        count_nx    = count;
        halt_cnt_nx = halt_cnt;
        last_nx     = last_seen;
        addr_nx     = dbg_addr;
        wdata_nx    = dbg_wdata;
        wen_nx      = 1'b0;
        sys_rst_nx  = sys_rst;
        err_nx      = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    base_nx     = base_addr;
                    count_nx    = '0;
                    err_nx      = 1'b0;
                    halt_cnt_nx = HC_W'(HALT_CYCLES - 1);
                    last_nx     = 1'b0;
                    sys_rst_nx  = 1'b1;
                    state_nx    = HALT;
                end
            end
            HALT: begin
                if (halt_cnt == '0)
                    state_nx = LOAD;
                else
                    halt_cnt_nx = halt_cnt - HC_W'(1);
            end
            // LOAD lingers one cycle after host_last so RELEASE follows the final dbg_wen.
            LOAD: begin
                if (last_seen) begin
                    state_nx = RELEASE;
                    if (csum_bad)
                        err_nx = 1'b1;
                end else if (hs) begin
                    if (is_payload) begin
                        if (count == CNT_W'(MAX_BYTES)) begin
                            err_nx = 1'b1;
                        end else begin
                            addr_nx  = base_q + 12'(count);
                            wdata_nx = host.host_data;
                            wen_nx   = 1'b1;
                            count_nx = count + CNT_W'(1);
                        end
                    end
                    if (host.host_last)
                        last_nx = 1'b1;
                end
            end
            RELEASE: begin
                state_nx   = IDLE;
                sys_rst_nx = csum_bad;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            base_q          <= '0;
            count           <= '0;
            halt_cnt        <= '0;
            last_seen       <= 1'b0;
            dbg_addr        <= '0;
            dbg_wdata       <= '0;
            dbg_wen         <= 1'b0;
            sys_rst         <= HOLD_AT_RESET;
            err             <= 1'b0;
            host.host_ready <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nx;
            base_q          <= base_nx;
            count           <= count_nx;
            halt_cnt        <= halt_cnt_nx;
            last_seen       <= last_nx;
            dbg_addr        <= addr_nx;
            dbg_wdata       <= wdata_nx;
            dbg_wen         <= wen_nx;
            sys_rst         <= sys_rst_nx;
            err             <= err_nx;
            host.host_ready <= (state_nx == LOAD) && !last_nx;
            busy            <= (state_nx != IDLE);
            done            <= (state_nx == RELEASE);
        end
    end

endmodule

// File: tb/tb_mcs4_loader.sv
// Self-checking bench for mcs4_loader: randomized image loads checked against a
// byte-list reference model of the expected ROM writes and handshake timing.
module tb_mcs4_loader;
    import mcs4::*;

    localparam int unsigned MAXB = 4;
    localparam int unsigned HALT = 3;
`ifdef MCS4_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          c;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    rom_addr_t   dbg_addr;
    byte_t       dbg_wdata;
    logic        dbg_wen, sys_rst, busy, done, err;

    int          cyc = 0;
    int          ntest = 0;
    int          nfail = 0;
    wr_t         wr_q[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  rom [4096];
    logic [11:0] mon_a;

    mcs4_loader_if host ();

    mcs4_loader #(
        .MAX_BYTES    (MAXB),
        .HALT_CYCLES  (HALT),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .host     (host),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_wen  (dbg_wen),
        .sys_rst  (sys_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dbg_wen === 1'b1) begin
            mon_a = dbg_addr;
            wr_q.push_back('{mon_a, dbg_wdata, cyc});
            rom[mon_a] = dbg_wdata;
        end
    end

    // Present one byte and hold it until accepted; returns the handshake cycle.
    task automatic send_byte(input logic [7:0] d, input bit last, output int hs);
        int unsigned waited = 0;
        host.host_data  = d;
        host.host_valid = 1'b1;
        host.host_last  = last;
        while (host.host_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (host.host_ready !== 1'b1) begin
            ntest++;
            nfail++;
            $display("FAIL handshake_timeout: host_ready=%b required 1", host.host_ready);
            hs = -1;
        end else begin
            hs = cyc + 1;
        end
        @(negedge clk);
        host.host_valid = 1'b0;
        host.host_last  = 1'b0;
    endtask

    // Load pay_q at base and check every externally visible effect.
    task automatic do_load(input logic [11:0] base, input bit gaps, input string name);
        int          n, npay, h, start_c, hs_last;
        int          hs[$];
        wr_t         exp_q[$];
        logic [7:0]  sum;
        logic [11:0] a;
        bit          exp_err, exp_sr, found;
        n    = pay_q.size();
        npay = CSUM ? n - 1 : n;
        sum  = '0;
        foreach (pay_q[i]) sum += pay_q[i];
        exp_sr  = CSUM && (sum != 8'h00);
        exp_err = (npay > int'(MAXB)) || exp_sr;
        wr_q.delete();

        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
        start_c   = cyc;
        base_addr = 12'($urandom);
        ntest++;
        if (busy !== 1'b1 || sys_rst !== 1'b1 || host.host_ready !== 1'b0 || err !== 1'b0) begin
            nfail++;
            $display("FAIL %s_halt: busy/sys_rst/ready/err=%b%b%b%b required 1100",
                     name, busy, sys_rst, host.host_ready, err);
        end

        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
                start = 1'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(pay_q[i], i == n - 1, h);
            hs.push_back(h);
            if (i < npay && i < int'(MAXB)) begin
                a = base + 12'(i);
                exp_q.push_back('{a, pay_q[i], h});
            end
        end
        hs_last = hs[n-1];

        ntest++;
        if (hs[0] != start_c + int'(HALT) + 1) begin
            nfail++;
            $display("FAIL %s_first_latency: got %0d required %0d", name, hs[0] - start_c, HALT + 1);
        end
        ntest++;
        if (host.host_ready !== 1'b0) begin
            nfail++;
            $display("FAIL %s_ready_drop: got %b required 0", name, host.host_ready);
        end

        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        ntest++;
        if (!found || cyc != hs_last + 1) begin
            nfail++;
            $display("FAIL %s_done_timing: got %0d cycles (found=%0d) required 2",
                     name, cyc - hs_last + 1, found);
        end
        ntest++;
        if (err !== exp_err || busy !== 1'b1) begin
            nfail++;
            $display("FAIL %s_err_at_done: err/busy=%b%b required %b1", name, err, busy, exp_err);
        end
        @(negedge clk);
        ntest++;
        if (done !== 1'b0 || busy !== 1'b0 || sys_rst !== exp_sr) begin
            nfail++;
            $display("FAIL %s_release: done/busy/sys_rst=%b%b%b required 00%b",
                     name, done, busy, sys_rst, exp_sr);
        end

        ntest++;
        if (wr_q.size() != exp_q.size()) begin
            nfail++;
            $display("FAIL %s_write_count: got %0d required %0d", name, wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            ntest++;
            if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data
                || wr_q[i].c != exp_q[i].c) begin
                nfail++;
                $display("FAIL %s_write[%0d]: got %h/%h@%0d required %h/%h@%0d", name, i,
                         wr_q[i].addr, wr_q[i].data, wr_q[i].c,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].c);
            end
        end
    endtask

    task automatic test_reset();
        host.host_data  = '0;
        host.host_valid = 1'b0;
        host.host_last  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        ntest++;
        if (host.host_ready !== 1'b0 || dbg_addr !== '0 || dbg_wdata !== '0 || dbg_wen !== 1'b0
            || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sys_rst !== 1'b1) begin
            nfail++;
            $display("FAIL reset_values: rdy=%b addr=%h wd=%h wen=%b busy=%b done=%b err=%b sys_rst=%b required 0/000/00/0/0/0/0/1",
                     host.host_ready, dbg_addr, dbg_wdata, dbg_wen, busy, done, err, sys_rst);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        ntest++;
        if (sys_rst !== 1'b1 || busy !== 1'b0 || host.host_ready !== 1'b0) begin
            nfail++;
            $display("FAIL hold_at_reset: sys_rst/busy/ready=%b%b%b required 100",
                     sys_rst, busy, host.host_ready);
        end
    endtask

    task automatic test_basic();
        pay_q = {8'hD5, 8'h20, 8'h40};
        do_load(12'h000, 1'b0, "basic");
        ntest++;
        if (rom[0] !== 8'hD5) begin
            nfail++;
            $display("FAIL basic_fetch_byte: got %h required d5", rom[0]);
        end
    endtask

    task automatic test_backpressure();
        pay_q = {8'h01, 8'h02, 8'h03, 8'h04};
        do_load(12'h123, 1'b1, "backpressure");
    endtask

    task automatic test_wrap();
        pay_q = {8'hA1, 8'hB2, 8'hC3};
        do_load(12'hFFE, 1'b0, "wrap");
    endtask

    task automatic test_overflow();
        pay_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_load(12'h040, 1'b0, "overflow");
    endtask

    task automatic test_reset_mid();
        int h;
        wr_q.delete();
        start     = 1'b1;
        base_addr = 12'h100;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h5A, 1'b0, h);
        send_byte(8'hA5, 1'b0, h);
        host.host_data  = 8'h77;
        host.host_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        ntest++;
        if (host.host_ready !== 1'b0 || dbg_addr !== '0 || dbg_wdata !== '0 || dbg_wen !== 1'b0
            || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || sys_rst !== 1'b1) begin
            nfail++;
            $display("FAIL midreset_values: rdy=%b addr=%h wd=%h wen=%b busy=%b done=%b err=%b sys_rst=%b required 0/000/00/0/0/0/0/1",
                     host.host_ready, dbg_addr, dbg_wdata, dbg_wen, busy, done, err, sys_rst);
        end
        host.host_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ntest++;
        if (wr_q.size() != 2 || rom[12'h100] !== 8'h5A || rom[12'h101] !== 8'hA5) begin
            nfail++;
            $display("FAIL midreset_kept: writes=%0d rom=%h%h required 2 5aa5",
                     wr_q.size(), rom[12'h100], rom[12'h101]);
        end
        pay_q = {8'h0F, 8'hF0, 8'h3C};
        do_load(12'h200, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int         n;
            logic [7:0] s;
            logic [7:0] b;
            n = $urandom_range(1, 6);
            s = '0;
            pay_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                pay_q.push_back(b);
                s += b;
            end
            if (CSUM && $urandom_range(0, 1) == 1) begin
                s -= pay_q[n-1];
                pay_q[n-1] = 8'h00 - s;
            end
            do_load(12'($urandom), 1'($urandom_range(0, 1)), "random");
        end
    endtask

`ifdef MCS4_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pay_q = {8'h10, 8'h20, 8'hD0};
        do_load(12'h300, 1'b0, "csum_good");
        pay_q = {8'h10, 8'h20, 8'hD1};
        do_load(12'h300, 1'b0, "csum_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_overflow();
        test_reset_mid();
`ifdef MCS4_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
